pulpito_uart_rx: RTL and testbench

PULPITO_UART_RX -- requirements
Module: pulpito_uart_rx

---
 rtl/pulpito_uart_pkg.sv | 21 ++
 rtl/pulpito_uart_rx_fifo.sv | 66 ++++++
 rtl/pulpito_uart_rx.sv | 195 +++++++++++++++++++
 tb/tb_pulpito_uart_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulpito_uart_pkg.sv
// Shared definitions for the pulpito UART receiver: oversampling constants
// and the receive FSM state encoding.
package pulpito_uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 8;

  // Tick-counter values at which the line is sampled.
  localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
  localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

endpackage

// File: rtl/pulpito_uart_rx_fifo.sv
// Receive FIFO: FIFO_DEPTH x 8-bit, power-of-two depth, pointers wrap
// naturally at their width. A push while full is accepted only when a pop
// frees the head entry in the same cycle.
module pulpito_uart_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned AW = $clog2(FIFO_DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  // Head reads as zero when empty so the output is clean after reset.
  assign rdata_o = empty_o ? 8'h00 : mem_q[rptr_q];

  // Pointer and occupancy update.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_en) wptr_d = wptr_q + AW'(1);
    if (rd_en) rptr_d = rptr_q + AW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset since empty gates the output.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pulpito_uart_rx.sv
// UART receiver with 16x oversampling, 8N1 framing and a receive FIFO with
// RTS flow control. Define PULPITO_UART_PARITY_EN to add a parity bit
// (PARITY_ODD selects odd parity, default even) making an 11-bit frame.
module pulpito_uart_rx
  import pulpito_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 54,
  parameter int unsigned FIFO_DEPTH = 8
`ifdef PULPITO_UART_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx_i,
  output logic       uart_rts_n_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]  sync_q, sync_d;
  logic        line_q, line_d;
  uart_state_e state_q, state_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        push_q, push_d;
  logic        frame_err_q, frame_err_d;
  logic        rts_q, rts_d;

  logic          rx_s, tick, start_edge, bit_tick, par_ok;
  logic          fifo_full, fifo_empty, pop;
  logic [CW-1:0] fifo_count;

  assign rx_s       = sync_q[1];
  assign tick       = (div_cnt_q == 16'(CLK_DIV - 1));
  assign start_edge = (state_q == ST_IDLE) && line_q && !rx_s;
  assign bit_tick   = tick && (tick_cnt_q == BIT_LAST);

  // Synchronizer, previous-level tracker and oversample divider; the
  // divider is realigned to the detected start edge.
  always_comb begin
    sync_d    = {sync_q[0], uart_rx_i};
    line_d    = rx_s;
    div_cnt_d = (start_edge || tick) ? 16'd0 : div_cnt_q + 16'd1;
  end

  // Frame FSM: start mid-bit check, data shift-in, stop-bit qualification.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d    = ST_START;
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
        end
      end
      ST_START: begin
        if (tick && tick_cnt_q == MID_LAST) begin
          tick_cnt_d = 4'd0;
          state_d    = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef PULPITO_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef PULPITO_UART_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          push_d      = rx_s && par_ok;
          frame_err_d = !rx_s;
          state_d     = rx_s ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RTS deasserts (goes high) once fewer than two entries are free.
  always_comb begin
    rts_d = (fifo_count >= CW'(FIFO_DEPTH - 1));
  end

  // Receiver state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b11;
      line_q      <= 1'b1;
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      rts_q       <= 1'b1;
    end else begin
      sync_q      <= sync_d;
      line_q      <= line_d;
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      rts_q       <= rts_d;
    end
  end

`ifdef PULPITO_UART_PARITY_EN
  logic par_err_q, par_err_d;
  logic parity_err_q, parity_err_d;

  // Parity result is captured at the parity-bit midpoint, reported at stop.
  always_comb begin
    par_err_d    = par_err_q;
    parity_err_d = 1'b0;
    if (start_edge) par_err_d = 1'b0;
    if (state_q == ST_PARITY && bit_tick)
      par_err_d = ((^{shift_q, rx_s}) != PARITY_ODD);
    if (state_q == ST_STOP && bit_tick)
      parity_err_d = par_err_q;
  end

  // Parity status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_err_q    <= par_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign par_ok       = !par_err_q;
  assign parity_err_o = parity_err_q;
`else
  assign par_ok       = 1'b1;
  assign parity_err_o = 1'b0;
`endif

  assign pop          = rx_valid_o && rx_ready_i;
  assign rx_valid_o   = !fifo_empty;
  assign overrun_o    = push_q && fifo_full && !pop;
  assign frame_err_o  = frame_err_q;
  assign uart_rts_n_o = rts_q;

  pulpito_uart_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (rx_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_pulpito_uart_rx.sv
// Scoreboard bench for pulpito_uart_rx: serial frames are driven bit by bit,
// expected bytes/error counts come from a frame-level model.
module tb_pulpito_uart_rx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;
  localparam int BIT     = 16 * CLK_DIV;
`ifdef PULPITO_UART_PARITY_EN
  localparam bit ODD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic       uart_rts_n;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun;

  always #5 clk = ~clk;

  pulpito_uart_rx #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(DEPTH)
`ifdef PULPITO_UART_PARITY_EN
    ,
    .PARITY_ODD(ODD)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx_i    (uart_rx),
    .uart_rts_n_o (uart_rts_n),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .frame_err_o  (frame_err),
    .parity_err_o (parity_err),
    .overrun_o    (overrun)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int frame_cnt = 0, par_cnt = 0, ovr_cnt = 0, vld_cycles = 0;
  int exp_frame = 0, exp_par = 0, exp_ovr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts pulses, checks head stability, pops the scoreboard.
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] e;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (frame_err)  frame_cnt++;
      if (parity_err) par_cnt++;
      if (overrun)    ovr_cnt++;
      if (rx_valid)   vld_cycles++;
      if (hold_prev && rx_valid) chk("data_hold", rx_data, prev_data);
      hold_prev = rx_valid && !rx_ready;
      prev_data = rx_data;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte actual=0x%0h expected=none t=%0t", rx_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", rx_data, e);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: decides what the receiver must do with one frame.
  task automatic issue(input logic [7:0] b, input bit stop_b, input bit bad_par);
    if (!stop_b) exp_frame++;
    if (bad_par) exp_par++;
    if (stop_b && !bad_par) begin
      if (!rx_ready && exp_q.size() == DEPTH) exp_ovr++;
      else exp_q.push_back(b);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop_b, input bit bad_par);
    uart_rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cyc(BIT);
    end
`ifdef PULPITO_UART_PARITY_EN
    uart_rx = (^b) ^ ODD ^ bad_par;
    wait_cyc(BIT);
`endif
    uart_rx = stop_b;
    wait_cyc(BIT);
    uart_rx = 1'b1;
    wait_cyc(BIT / 2);
  endtask

  task automatic frame(input logic [7:0] b, input bit stop_b, input bit bad_par);
    issue(b, stop_b, bad_par);
    send(b, stop_b, bad_par);
  endtask

  task automatic check_errs(input string tag);
    chk({tag, "_frame_err"}, frame_cnt, exp_frame);
    chk({tag, "_parity_err"}, par_cnt, exp_par);
    chk({tag, "_overrun"}, ovr_cnt, exp_ovr);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    wait_cyc(4);
    chk({tag, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    int v0;
    logic [7:0] b;
    bit s, p;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rts", uart_rts_n, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cyc(20);
    chk("idle_rts", uart_rts_n, 0);

    // Single byte, valid for exactly one cycle with ready held high
    v0 = vld_cycles;
    frame(8'hA5, 1'b1, 1'b0);
    wait_cyc(10);
    chk("a5_valid_cycles", vld_cycles - v0, 1);
    chk("a5_valid_low", rx_valid, 0);
    check_errs("a5");

    // Short low glitch must be ignored
    uart_rx = 1'b0;
    wait_cyc(3 * CLK_DIV);
    uart_rx = 1'b1;
    wait_cyc(2 * BIT);
    chk("glitch_valid", rx_valid, 0);
    check_errs("glitch");

    // Framing error, then recovery
    frame(8'h3C, 1'b0, 1'b0);
    wait_cyc(4);
    chk("ferr_valid", rx_valid, 0);
    check_errs("ferr");
    frame(8'h55, 1'b1, 1'b0);
    wait_drain("ferr55");

    // Fill the FIFO with the consumer stalled; ninth byte overruns
    rx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      frame(8'(i), 1'b1, 1'b0);
      chk($sformatf("rts_after_%0d", i + 1), uart_rts_n, (exp_q.size() >= DEPTH - 1) ? 1 : 0);
    end
    check_errs("ovr");
    rx_ready = 1'b1;
    wait_drain("ovr");
    chk("ovr_rts_release", uart_rts_n, 0);

    // Reset during data bit 4: remaining bits held high so no new edge
    b = {4'hF, 4'($urandom_range(0, 15))};
    uart_rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      wait_cyc(BIT);
    end
    uart_rx = 1'b1;
    wait_cyc(BIT / 2);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(5 * BIT);
    chk("midrst_valid", rx_valid, 0);
    check_errs("midrst");
    frame(8'hC3, 1'b1, 1'b0);
    wait_drain("midrst_c3");

`ifdef PULPITO_UART_PARITY_EN
    // Parity: 0x01 with wrong then correct parity bit
    frame(8'h01, 1'b1, 1'b1);
    wait_cyc(4);
    chk("par_bad_valid", rx_valid, 0);
    check_errs("par_bad");
    frame(8'h01, 1'b1, 1'b0);
    wait_drain("par_good");
`endif

    // Randomized frames with occasional bad stop (and parity) bits
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 7) != 0);
`ifdef PULPITO_UART_PARITY_EN
      p = ($urandom_range(0, 7) == 0);
`else
      p = 1'b0;
`endif
      frame(b, s, p);
    end
    wait_drain("rand");
    check_errs("final");
    chk("final_valid", rx_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
